// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: after a vending transaction, hands out the item (if paid for)
// and then returns change or a refund one coin at a time using greedy denominations.
module vend_dispense_ctrl #(
    parameter logic [7:0] D3 = 8'd10,
    parameter logic [7:0] D2 = 8'd5,
    parameter logic [7:0] D1 = 8'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       end_trans,
    input  logic [7:0] sum_money,
    input  logic [7:0] price,
    input  logic [1:0] item_select,
    input  logic       item_ack,
    input  logic       coin_ack,
    output logic       item_valid,
    output logic [1:0] item_id,
    output logic       coin_valid,
    output logic [1:0] coin_type,
    output logic       busy,
    output logic       done,
    output logic       refund,
    output logic [7:0] change_total
);

    localparam logic [7:0] D0 = 8'd1;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ITEM,
        SELECT_COIN,
        COIN,
        FINISH
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] price_q, price_d;
    logic [7:0] remain_q, remain_d;
    logic [7:0] change_q, change_d;
    logic [1:0] itemId_q, itemId_d;
    logic [1:0] coinType_q, coinType_d;
    logic       refund_q, refund_d;
    logic       itemValid_q, coinValid_q, busy_q, done_q;

    function automatic logic [7:0] coinValue(input logic [1:0] kind);
        case (kind)
            2'd3:    coinValue = D3;
            2'd2:    coinValue = D2;
            2'd1:    coinValue = D1;
            default: coinValue = D0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        price_d    = price_q;
        remain_d   = remain_q;
        change_d   = change_q;
        itemId_d   = itemId_q;
        coinType_d = coinType_q;
        refund_d   = refund_q;

        case (state_q)
            IDLE: begin
                if (end_trans) begin
                    sum_d    = sum_money;
                    price_d  = price;
                    itemId_d = item_select;
                    state_d  = LATCH;
                end
            end
            LATCH: begin
                if (sum_q >= price_q) begin
                    remain_d = sum_q - price_q;
                    refund_d = 1'b0;
                    state_d  = ITEM;
                end else begin
                    remain_d = sum_q;
                    refund_d = 1'b1;
                    state_d  = SELECT_COIN;
                end
                change_d = remain_d;
            end
            ITEM: begin
                if (item_ack) begin
                    state_d = SELECT_COIN;
                end
            end
            SELECT_COIN: begin
                if (remain_q == 8'd0) begin
                    state_d = FINISH;
                end else begin
                    if (remain_q >= D3) begin
                        coinType_d = 2'd3;
                    end else if (remain_q >= D2) begin
                        coinType_d = 2'd2;
                    end else if (remain_q >= D1) begin
                        coinType_d = 2'd1;
                    end else begin
                        coinType_d = 2'd0;
                    end
                    state_d = COIN;
                end
            end
            COIN: begin
                // Guarded subtraction keeps remain from ever wrapping below zero.
                if (coin_ack) begin
                    if (coinValue(coinType_q) <= remain_q) begin
                        remain_d = remain_q - coinValue(coinType_q);
                    end
                    state_d = SELECT_COIN;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            refund_d = 1'b0;
        end
    end

    // Handshake and status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sum_q       <= 8'd0;
            price_q     <= 8'd0;
            remain_q    <= 8'd0;
            change_q    <= 8'd0;
            itemId_q    <= 2'd0;
            coinType_q  <= 2'd0;
            refund_q    <= 1'b0;
            itemValid_q <= 1'b0;
            coinValid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            price_q     <= price_d;
            remain_q    <= remain_d;
            change_q    <= change_d;
            itemId_q    <= itemId_d;
            coinType_q  <= coinType_d;
            refund_q    <= refund_d;
            itemValid_q <= (state_d == ITEM);
            coinValid_q <= (state_d == COIN);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == FINISH);
        end
    end

    assign item_valid   = itemValid_q;
    assign item_id      = itemId_q;
    assign coin_valid   = coinValid_q;
    assign coin_type    = coinType_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign refund       = refund_q;
    assign change_total = change_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: table of transactions with expected item/coin/done
// events queued in a scoreboard, plus hand sequences for busy re-trigger and abort.
module tb_vend_dispense_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       end_trans;
    logic [7:0] sum_money;
    logic [7:0] price;
    logic [1:0] item_select;
    logic       item_ack;
    logic       coin_ack;
    logic       item_valid;
    logic [1:0] item_id;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       busy;
    logic       done;
    logic       refund;
    logic [7:0] change_total;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] sum;
        logic [7:0] price;
        logic [1:0] item;
        int         itemDly;
        int         coinDly;
        logic [7:0] expChange;
        logic       expRefund;
        int         n3;
        int         n2;
        int         n1;
        int         n0;
        int         expLat;
        bit         junk;
    } vec_t;

    typedef struct {
        int kind;
        int value;
    } ev_t;

    ev_t        sbQ[$];
    vec_t       vecs[10];
    int         itemDly = 0;
    int         coinDly = 0;
    int         itemWait = 0;
    int         coinWait = 0;
    logic [1:0] heldType = 2'd0;
    bit         monEn = 1'b0;

    vend_dispense_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .end_trans    (end_trans),
        .sum_money    (sum_money),
        .price        (price),
        .item_select  (item_select),
        .item_ack     (item_ack),
        .coin_ack     (coin_ack),
        .item_valid   (item_valid),
        .item_id      (item_id),
        .coin_valid   (coin_valid),
        .coin_type    (coin_type),
        .busy         (busy),
        .done         (done),
        .refund       (refund),
        .change_total (change_total)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic popCheck(input int kind, input logic [31:0] actual, input string name);
        ev_t ev;
        checks++;
        if (sbQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s actual=unexpected event kind %0d value %0d required=no event", name, kind, actual);
        end else begin
            ev = sbQ.pop_front();
            if (ev.kind != kind || actual !== ev.value) begin
                errors++;
                $display("[TB] FAIL %s actual=kind %0d value %0d required=kind %0d value %0d",
                         name, kind, actual, ev.kind, ev.value);
            end
        end
    endtask

    // Ack generator and output monitor share one process so acks and observations stay ordered.
    initial begin
        item_ack = 1'b0;
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                item_ack = 1'b0;
                coin_ack = 1'b0;
                itemWait = 0;
                coinWait = 0;
            end else begin
                itemWait = item_valid ? itemWait + 1 : 0;
                coinWait = coin_valid ? coinWait + 1 : 0;
                item_ack = (itemDly == 0) ? 1'b1 : (item_valid && itemWait > itemDly);
                coin_ack = (coinDly == 0) ? 1'b1 : (coin_valid && coinWait > coinDly);
                if (monEn) begin
                    if (item_valid || coin_valid)
                        checkOutput("validExclusive", {31'd0, item_valid & coin_valid}, 32'd0);
                    if (coin_valid) begin
                        if (coinWait == 1) heldType = coin_type;
                        else checkOutput("coinTypeStable", {30'd0, coin_type}, {30'd0, heldType});
                    end
                    if (item_valid && item_ack) popCheck(0, {30'd0, item_id}, "itemEvent");
                    if (coin_valid && coin_ack) popCheck(1, {30'd0, coin_type}, "coinEvent");
                    if (done) popCheck(2, {31'd0, refund}, "doneEvent");
                end
            end
        end
    end

    task automatic applyStimulus(input vec_t v);
        int cyc;
        bit seen;
        itemDly = v.itemDly;
        coinDly = v.coinDly;
        if (!v.expRefund) sbQ.push_back('{kind: 0, value: int'(v.item)});
        for (int k = 0; k < v.n3; k++) sbQ.push_back('{kind: 1, value: 3});
        for (int k = 0; k < v.n2; k++) sbQ.push_back('{kind: 1, value: 2});
        for (int k = 0; k < v.n1; k++) sbQ.push_back('{kind: 1, value: 1});
        for (int k = 0; k < v.n0; k++) sbQ.push_back('{kind: 1, value: 0});
        sbQ.push_back('{kind: 2, value: int'(v.expRefund)});

        @(negedge clk);
        sum_money   = v.sum;
        price       = v.price;
        item_select = v.item;
        end_trans   = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        end_trans   = 1'b0;
        sum_money   = 8'($urandom);
        price       = 8'($urandom);
        item_select = 2'($urandom);
        seen = 1'b0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            if (v.junk && cyc == 2) begin
                end_trans   = 1'b1;
                sum_money   = 8'd99;
                price       = 8'd1;
                item_select = 2'd3;
            end else begin
                end_trans = 1'b0;
            end
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        checkOutput("doneSeen", {31'd0, seen}, 32'd1);
        if (v.expLat != 0) checkOutput("latency", cyc, v.expLat);
        checkOutput("changeAtDone", {24'd0, change_total}, {24'd0, v.expChange});
        checkOutput("busyAtDone", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("donePulseWidth", {31'd0, done}, 32'd0);
        checkOutput("busyIdle", {31'd0, busy}, 32'd0);
        checkOutput("refundCleared", {31'd0, refund}, 32'd0);
        checkOutput("changeHeld", {24'd0, change_total}, {24'd0, v.expChange});
        checkOutput("scoreboardDrained", sbQ.size(), 32'd0);
        sbQ.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_itemValid"}, {31'd0, item_valid}, 32'd0);
        checkOutput({tag, "_coinValid"}, {31'd0, coin_valid}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_refund"}, {31'd0, refund}, 32'd0);
        checkOutput({tag, "_itemId"}, {30'd0, item_id}, 32'd0);
        checkOutput({tag, "_coinType"}, {30'd0, coin_type}, 32'd0);
        checkOutput({tag, "_change"}, {24'd0, change_total}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        bit doneAfter;
        rst         = 1'b1;
        end_trans   = 1'b0;
        sum_money   = 8'd0;
        price       = 8'd0;
        item_select = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idleWithoutEndTrans", {31'd0, busy}, 32'd0);
        monEn = 1'b1;

        //          sum     price  item iD cD change  ref  n3 n2 n1 n0 lat junk
        vecs[0] = '{8'd20,  8'd13,  2'd2, 0, 0, 8'd7,   1'b0, 0, 1, 1, 0, 0, 1'b0};
        vecs[1] = '{8'd8,   8'd15,  2'd1, 0, 0, 8'd8,   1'b1, 0, 1, 1, 1, 0, 1'b0};
        vecs[2] = '{8'd12,  8'd12,  2'd3, 0, 0, 8'd0,   1'b0, 0, 0, 0, 0, 4, 1'b0};
        vecs[3] = '{8'd255, 8'd0,   2'd1, 0, 3, 8'd255, 1'b0, 25, 1, 0, 0, 0, 1'b0};
        vecs[4] = '{8'd0,   8'd0,   2'd0, 0, 0, 8'd0,   1'b0, 0, 0, 0, 0, 4, 1'b0};
        vecs[5] = '{8'd0,   8'd5,   2'd2, 0, 0, 8'd0,   1'b1, 0, 0, 0, 0, 3, 1'b0};
        vecs[6] = '{8'd19,  8'd0,   2'd3, 2, 1, 8'd19,  1'b0, 1, 1, 2, 0, 0, 1'b0};
        vecs[7] = '{8'd100, 8'd97,  2'd0, 0, 0, 8'd3,   1'b0, 0, 0, 1, 1, 0, 1'b0};
        vecs[8] = '{8'd4,   8'd255, 2'd2, 0, 2, 8'd4,   1'b1, 0, 0, 2, 0, 0, 1'b0};
        vecs[9] = '{8'd20,  8'd13,  2'd2, 1, 0, 8'd7,   1'b0, 0, 1, 1, 0, 0, 1'b1};

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
        end

        // Abort in the middle of a slow coin handshake.
        itemDly = 0;
        coinDly = 3;
        sbQ.push_back('{kind: 0, value: 1});
        @(negedge clk);
        sum_money   = 8'd255;
        price       = 8'd0;
        item_select = 2'd1;
        end_trans   = 1'b1;
        @(posedge clk);
        #1 end_trans = 1'b0;
        n = 0;
        while (!coin_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reachedCoin", {31'd0, coin_valid}, 32'd1);
        #2 rst = 1'b1;
        #1 checkAllZero("abort");
        rst = 1'b0;
        doneAfter = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) doneAfter = 1'b1;
        end
        checkOutput("noDoneAfterAbort", {31'd0, doneAfter}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy}, 32'd0);
        checkOutput("abortQueue", sbQ.size(), 32'd0);
        sbQ.delete();

        applyStimulus(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 Parameter: D3, 10, largest coin value; D2, 5; D1, 2; D0, 1 (smallest coin, fixed at 1); all SHALL be strictly descending.
REQ-002 Port: clk  in  1  single clock, rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-high.
REQ-004 Port: end_trans  in  1  transaction-complete strobe from the vending FSM output logic.
REQ-005 Port: sum_money  in  8  total money inserted, unsigned, valid while end_trans=1.
REQ-006 Port: price  in  8  price of selected item, unsigned, valid while end_trans=1.
REQ-007 Port: item_select  in  2  selected item code, valid while end_trans=1.
REQ-008 Port: item_ack  in  1  item dispenser accepted item_valid.
REQ-009 Port: coin_ack  in  1  coin hopper accepted coin_valid.
REQ-010 Port: item_valid  out  1  request to dispense item_id.
REQ-011 Port: item_id  out  2  latched item code.
REQ-012 Port: coin_valid  out  1  request to eject one coin of coin_type.
REQ-013 Port: coin_type  out  2  3=D3, 2=D2, 1=D1, 0=D0.
REQ-014 Port: busy  out  1  high in every state except IDLE.
REQ-015 Port: done  out  1  one-cycle completion pulse back to the vending FSM.
REQ-016 Port: refund  out  1  high with done when sum_money < price (no item given).
REQ-017 Port: change_total  out  8  change/refund amount latched for the current transaction.

Function
REQ-018 States SHALL be IDLE, LATCH, ITEM, SELECT_COIN, COIN, FINISH; all outputs registered.
REQ-019 IDLE: on clk edge with end_trans=1, latch sum_money, price, item_select into internal registers and go to LATCH; end_trans=0 stays IDLE.
REQ-020 end_trans SHALL be ignored in every state except IDLE (no re-latch, no queueing).
REQ-021 LATCH: if sum >= price, remaining = sum - price, refund=0, next ITEM; else remaining = sum, refund=1, next SELECT_COIN (item skipped).
REQ-022 change_total SHALL be loaded with the initial remaining value in LATCH and hold until next latch or reset.
REQ-023 ITEM: item_valid=1 with item_id stable until the cycle item_ack=1; next cycle item_valid=0, state SELECT_COIN.
REQ-024 SELECT_COIN: remaining=0 -> FINISH; else coin_type = largest Dk <= remaining, state COIN (one cycle, greedy).
REQ-025 COIN: coin_valid=1, coin_type stable until coin_ack=1; on ack remaining -= value(coin_type), coin_valid deasserts, next SELECT_COIN.
REQ-026 coin_ack/item_ack asserted outside their wait states SHALL be ignored; coin_valid and item_valid never high together.
REQ-027 Minimum latency end_trans to done with ack tied high: sum=price -> 4 cycles (LATCH, ITEM, SELECT_COIN, FINISH).
REQ-028 FINISH: done=1 for exactly one cycle, refund valid same cycle, then IDLE; refund cleared on return to IDLE.
REQ-029 remaining SHALL be 8-bit unsigned and never underflow; subtraction performed only for a selected coin <= remaining.
REQ-030 sum=0 and price=0: no item skipped, item dispensed, zero coins, done.

Reset
REQ-031 rst=1 SHALL immediately force IDLE; item_valid, coin_valid, busy, done, refund = 0; item_id, coin_type = 0; change_total and internal registers = 0.
REQ-032 rst mid-transaction SHALL abort without completing handshakes; no done pulse is produced for the aborted transaction.

Verification
REQ-033 sum=20, price=13, item=2, acks tied high -> item_id=2 dispensed, coins 5,2 in order, change_total=7, refund=0, done pulse.
REQ-034 sum=8, price=15 -> no item_valid, coins 5,2,1, refund=1 with done, change_total=8.
REQ-035 sum=price=12 -> item dispensed, zero coins, done at cycle 4 after end_trans.
REQ-036 sum=255, price=0, coin_ack delayed 3 cycles per coin -> 25xD3 then 1xD2, coin_type stable during each wait, change_total=255.
REQ-037 end_trans pulsed while busy -> ignored, latched values unchanged; rst asserted during COIN -> outputs zero at once, IDLE, no done.
